rgb_frame_monitor: RTL
======================

RGB_FRAME_MONITOR -- requirements
Module: rgb_frame_monitor

Interface
REQ-001 Parameter IMG_WIDTH, default 400, active pixels per line.
REQ-002 Parameter IMG_HEIGHT, default 300, lines per frame.
REQ-003 Parameter NUM_CH, default 3, colour channels per pixel.
REQ-004 Parameter DATA_W, default 8, bits per channel.
REQ-005 Parameter CSUM_W, default 24, bits per channel checksum.
REQ-006 Parameter CONTINUOUS, default 0; 1 = auto re-arm after each frame.
REQ-007 Parameter EOL_CHECK, default 1; 1 = iEol used for line-length checks, 0 = iEol ignored.
REQ-008 pixclk  in  1  sole clock; all logic on rising edge.
REQ-009 reset  in  1  synchronous, active-high reset.
REQ-010 arm  in  1  pulse; starts frame capture from IDLE or DONE.
REQ-011 clr_err  in  1  pulse; clears sticky error flags.
REQ-012 valid  in  1  pixel qualifier.
REQ-013 iData  in  NUM_CH*DATA_W  pixel; channel 0 in MSBs (red for RGB).
REQ-014 iEol  in  1  last pixel of line, qualified by valid.
REQ-015 x_coord  out  $clog2(IMG_WIDTH)  current pixel column.
REQ-016 y_coord  out  $clog2(IMG_HEIGHT)  current line.
REQ-017 line_done  out  1  one-cycle pulse at each completed line.
REQ-018 frame_done  out  1  one-cycle pulse at completed frame.
REQ-019 frame_cnt  out  16  completed frames, wraps at 2^16.
REQ-020 csum  out  NUM_CH*CSUM_W  per-channel checksum of last completed frame.
REQ-021 err_short, err_long, err_overrun  out  1 each  sticky error flags.
REQ-022 busy  out  1  high in ACTIVE.

Function
REQ-023 valid, iData, iEol registered one stage (valid_r, data_r, eol_r); all counting uses registered copies, so latency input -> coordinate/pulse update is 2 cycles.
REQ-024 States IDLE, ACTIVE, DONE; IDLE->ACTIVE on arm; ACTIVE->DONE on last pixel of frame; DONE->ACTIVE on arm, or next cycle unconditionally when CONTINUOUS=1.
REQ-025 Entering ACTIVE clears x_coord, y_coord and all channel accumulators.
REQ-026 In ACTIVE each valid_r adds every channel of data_r to its accumulator, modulo 2^CSUM_W.
REQ-027 In ACTIVE valid_r with x_coord<IMG_WIDTH-1 and no eol_r increments x_coord.
REQ-028 valid_r with x_coord==IMG_WIDTH-1 sets x_coord=0, pulses line_done, increments y_coord; if EOL_CHECK=1 and eol_r=0, err_long sets.
REQ-029 EOL_CHECK=1, valid_r with eol_r=1 and x_coord<IMG_WIDTH-1: err_short sets, line treated as complete (x_coord=0, line_done, y advance).
REQ-030 Line completion at y_coord==IMG_HEIGHT-1: y_coord=0, frame_done pulses same cycle as line_done, frame_cnt increments, csum loads final accumulator values (including that pixel), state->DONE.
REQ-031 csum holds between frame_done pulses; unaffected by arm.
REQ-032 valid_r in DONE (CONTINUOUS=0) sets err_overrun, pixel discarded; valid_r in IDLE discarded silently.
REQ-033 Error set and clr_err in same cycle: set wins.
REQ-034 arm while ACTIVE ignored; arm in DONE coincident with valid_r: that pixel discarded, counting starts next pixel.
REQ-035 CONTINUOUS=1: a pixel arriving in the single DONE cycle sets err_overrun.

Reset
REQ-036 reset forces state IDLE; x_coord, y_coord, frame_cnt, csum, accumulators, valid_r, all pulses and error flags to 0; busy=0.
REQ-037 reset mid-frame abandons frame without frame_done; csum returns to 0.

Structure
REQ-038 frame_mon_state_t enum (IDLE, ACTIVE, DONE) and default geometry constants (400, 300) live in generic_pack.
REQ-039 Per-channel accumulation in sub-module rgb_channel_accum (DATA_W in, CSUM_W accumulator, clear/enable/load), instantiated NUM_CH times by generate.

Verification
REQ-040 IMG_WIDTH=4, IMG_HEIGHT=3, arm, 12 valid pixels all channels =1 -> 3 line_done, one frame_done on pixel 12, csum each channel =12, frame_cnt=1, state DONE.
REQ-041 Same geometry, iEol on 3rd pixel of line 0 -> err_short=1, line_done that cycle, next pixel at x=0,y=1.
REQ-042 4th pixel without iEol (EOL_CHECK=1) -> err_long=1; with EOL_CHECK=0 -> no error.
REQ-043 CONTINUOUS=0, pixel after frame_done without arm -> err_overrun=1, csum unchanged; clr_err -> 0.
REQ-044 CONTINUOUS=1, two back-to-back frames, one idle cycle between -> frame_cnt=2, no errors, csum from second frame only.
REQ-045 reset asserted at x=2,y=1 -> next cycle all outputs 0, IDLE; frame_done never pulses.

Source files
------------

// File: rtl/generic_pack.sv
// Shared types and default geometry for the RGB frame monitor.
// Channel 0 occupies the most significant slice of a packed pixel or checksum word.
package generic_pack;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        DONE   = 2'd2
    } frame_mon_state_t;

    localparam int DEF_IMG_WIDTH  = 400;
    localparam int DEF_IMG_HEIGHT = 300;

    function automatic int chan_lsb(input int ch, input int num_ch, input int width);
        return (num_ch - 1 - ch) * width;
    endfunction

endpackage

// File: rtl/rgb_frame_monitor_if.sv
// Pixel stream carried into the frame monitor: qualifier, packed pixel, end-of-line marker.
interface rgb_frame_monitor_if #(
    parameter int NUM_CH = 3,
    parameter int DATA_W = 8
);
    logic                     valid;
    logic [NUM_CH*DATA_W-1:0] iData;
    logic                     iEol;

    modport master (output valid, iData, iEol);
    modport slave  (input  valid, iData, iEol);
endinterface

// File: rtl/rgb_channel_accum.sv
// One colour channel's running sum; csum captures the sum including the pixel seen on load.
module rgb_channel_accum #(
    parameter int DATA_W = 8,
    parameter int CSUM_W = 24
) (
    input  logic              pixclk,
    input  logic              reset,
    input  logic              clear,
    input  logic              enable,
    input  logic              load,
    input  logic [DATA_W-1:0] din,
    output logic [CSUM_W-1:0] csum
);
    logic [CSUM_W-1:0] acc;
    logic [CSUM_W-1:0] acc_next;

    assign acc_next = acc + CSUM_W'(din);

    always_ff @(posedge pixclk) begin
        if (reset) begin
            acc  <= '0;
            csum <= '0;
        end else begin
            if (clear) begin
                acc <= '0;
            end else if (enable) begin
                acc <= acc_next;
            end
            if (load) begin
                csum <= acc_next;
            end
        end
    end
endmodule

// File: rtl/rgb_frame_monitor.sv
// Frame monitor: tracks pixel position, line/frame completion, per-channel checksums
// and sticky geometry errors on a registered copy of the incoming pixel stream.
module rgb_frame_monitor
    import generic_pack::*;
#(
    parameter int IMG_WIDTH  = DEF_IMG_WIDTH,
    parameter int IMG_HEIGHT = DEF_IMG_HEIGHT,
    parameter int NUM_CH     = 3,
    parameter int DATA_W     = 8,
    parameter int CSUM_W     = 24,
    parameter bit CONTINUOUS = 1'b0,
    parameter bit EOL_CHECK  = 1'b1,
    localparam int X_W = $clog2(IMG_WIDTH),
    localparam int Y_W = $clog2(IMG_HEIGHT)
) (
    input  logic                     pixclk,
    input  logic                     reset,
    input  logic                     arm,
    input  logic                     clr_err,
    rgb_frame_monitor_if.slave       pix,
    output logic [X_W-1:0]           x_coord,
    output logic [Y_W-1:0]           y_coord,
    output logic                     line_done,
    output logic                     frame_done,
    output logic [15:0]              frame_cnt,
    output logic [NUM_CH*CSUM_W-1:0] csum,
    output logic                     err_short,
    output logic                     err_long,
    output logic                     err_overrun,
    output logic                     busy
);
    frame_mon_state_t state;

    logic                     valid_r;
    logic                     eol_r;
    logic [NUM_CH*DATA_W-1:0] data_r;

    logic accept, last_x, last_y, eol_seen, line_end, frame_end, start;

    always_ff @(posedge pixclk) begin
        if (reset) begin
            valid_r <= 1'b0;
            eol_r   <= 1'b0;
            data_r  <= '0;
        end else begin
            valid_r <= pix.valid;
            eol_r   <= pix.iEol;
            data_r  <= pix.iData;
        end
    end

    assign accept    = (state == ACTIVE) && valid_r;
    assign last_x    = (x_coord == X_W'(IMG_WIDTH - 1));
    assign last_y    = (y_coord == Y_W'(IMG_HEIGHT - 1));
    assign eol_seen  = EOL_CHECK && eol_r;
    assign line_end  = accept && (last_x || eol_seen);
    assign frame_end = line_end && last_y;
    // Re-arm from DONE discards any pixel arriving that same cycle (accept is ACTIVE-only).
    assign start     = ((state == IDLE) && arm) || ((state == DONE) && (arm || CONTINUOUS));

    always_ff @(posedge pixclk) begin
        if (reset) begin
            state       <= IDLE;
            busy        <= 1'b0;
            x_coord     <= '0;
            y_coord     <= '0;
            line_done   <= 1'b0;
            frame_done  <= 1'b0;
            frame_cnt   <= '0;
            err_short   <= 1'b0;
            err_long    <= 1'b0;
            err_overrun <= 1'b0;
        end else begin
            line_done  <= line_end;
            frame_done <= frame_end;
            if (clr_err) begin
                err_short   <= 1'b0;
                err_long    <= 1'b0;
                err_overrun <= 1'b0;
            end
            case (state)
                IDLE, DONE: begin
                    if ((state == DONE) && valid_r) begin
                        err_overrun <= 1'b1;
                    end
                    if (start) begin
                        state   <= ACTIVE;
                        busy    <= 1'b1;
                        x_coord <= '0;
                        y_coord <= '0;
                    end
                end
                ACTIVE: begin
                    if (valid_r) begin
                        if (last_x && EOL_CHECK && !eol_r) begin
                            err_long <= 1'b1;
                        end
                        if (eol_seen && !last_x) begin
                            err_short <= 1'b1;
                        end
                        if (last_x || eol_seen) begin
                            x_coord <= '0;
                            if (last_y) begin
                                y_coord   <= '0;
                                frame_cnt <= frame_cnt + 16'd1;
                                state     <= DONE;
                                busy      <= 1'b0;
                            end else begin
                                y_coord <= y_coord + 1'b1;
                            end
                        end else begin
                            x_coord <= x_coord + 1'b1;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch
        localparam int D_LSB = chan_lsb(ch, NUM_CH, DATA_W);
        localparam int C_LSB = chan_lsb(ch, NUM_CH, CSUM_W);
        rgb_channel_accum #(
            .DATA_W (DATA_W),
            .CSUM_W (CSUM_W)
        ) u_accum (
            .pixclk (pixclk),
            .reset  (reset),
            .clear  (start),
            .enable (accept),
            .load   (frame_end),
            .din    (data_r[D_LSB +: DATA_W]),
            .csum   (csum[C_LSB +: CSUM_W])
        );
    end
endmodule
